// File: rtl/sipo_pkg.sv
// Shared types for the sipo_deser serial-in/parallel-out deserializer.
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    HOLD  = 2'd3
  } sipo_state_t;

  localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/sipo_deser_bit_cnt.sv
// bit_cnt: modulo-N up-counter with enable, synchronous clear and terminal-count flag.
module bit_cnt #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  output logic [$clog2(N)-1:0] cnt,
  output logic                 tc
);

  localparam int W = $clog2(N);

  assign tc = (cnt == W'(N - 1));

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// sipo_deser: strobed serial bits -> WIDTH-bit word under a valid/ready handshake.
// Optional even-parity check after the data bits is enabled by SIPO_DESER_PARITY_EN.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic             sin,
  input  logic             sin_en,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             ovr_clr
`ifdef SIPO_DESER_PARITY_EN
  ,
  output logic             par_err
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  sipo_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;
  logic             accept;
  logic             handshake;
  logic             start_frame;

  assign accept      = (state_q == SHIFT) && sin_en;
  assign handshake   = (state_q == HOLD) && dout_ready;
  assign start_frame = start && ((state_q == IDLE) || handshake);

  assign dout_valid  = (state_q == HOLD);
  assign busy        = (state_q == SHIFT) || (state_q == PAR);

  bit_cnt #(.N(WIDTH)) u_cnt (
    .clk  (clk),
    .rst_n(clr_n),
    .en   (accept),
    .clr  (start_frame),
    .cnt  (cnt),
    .tc   (last_bit)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = SHIFT;
      SHIFT: if (accept && last_bit) begin
`ifdef SIPO_DESER_PARITY_EN
        state_d = PAR;
`else
        state_d = HOLD;
`endif
      end
      PAR:   if (sin_en) state_d = HOLD;
      HOLD:  if (dout_ready) state_d = start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      dout <= '0;
    end else if (start_frame) begin
      dout <= '0;
    end else if (accept) begin
      if (MSB_FIRST) dout <= {dout[WIDTH-2:0], sin};
      else           dout <= {sin, dout[WIDTH-1:1]};
    end
  end

  // A dropped start outranks a same-cycle clear so the event is never lost.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      overrun <= 1'b0;
    end else if ((state_q == HOLD) && start && !dout_ready) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

`ifdef SIPO_DESER_PARITY_EN
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      par_err <= 1'b0;
    end else if ((state_q == PAR) && sin_en) begin
      par_err <= ^{dout, sin};
    end else if (handshake) begin
      par_err <= 1'b0;
    end
  end
`endif

  cnt_clear_on_start: assert property (@(posedge clk) disable iff (!clr_n)
    start_frame |=> (cnt == '0));

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser: one MSB-first and one LSB-first instance share the stimulus.
module tb_sipo_deser;

  logic       clk = 1'b0;
  logic       clr_n, start, sin, sin_en, dout_ready, ovr_clr;
  logic [7:0] dout_m, dout_l;
  logic       valid_m, valid_l, busy_m, busy_l, ovr_m, ovr_l;
`ifdef SIPO_DESER_PARITY_EN
  logic       perr_m, perr_l;
`endif

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] last_seq = '0;
  logic       par_flip = 1'b0;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .clr_n(clr_n), .start(start), .sin(sin), .sin_en(sin_en),
    .dout(dout_m), .dout_valid(valid_m), .dout_ready(dout_ready),
    .busy(busy_m), .overrun(ovr_m), .ovr_clr(ovr_clr)
`ifdef SIPO_DESER_PARITY_EN
    , .par_err(perr_m)
`endif
  );

  sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .clr_n(clr_n), .start(start), .sin(sin), .sin_en(sin_en),
    .dout(dout_l), .dout_valid(valid_l), .dout_ready(dout_ready),
    .busy(busy_l), .overrun(ovr_l), .ovr_clr(ovr_clr)
`ifdef SIPO_DESER_PARITY_EN
    , .par_err(perr_l)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic handshake();
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
  endtask

  // Sends seq[7] first; optional idle gaps after each bit with counter-hold checks.
  task automatic send_seq(input logic [7:0] seq, input int gap, input bit chk_cnt);
    last_seq = seq;
    for (int i = 7; i >= 0; i--) begin
      if (i == 0) check("valid_before_last_bit", valid_m, 1'b0);
      sin    = seq[i];
      sin_en = 1'b1;
      tick();
      sin_en = 1'b0;
      sin    = 1'b0;
      for (int g = 0; g < gap; g++) tick();
      if (chk_cnt && i > 0) check("cnt_holds_in_gap", dut_m.cnt, 32'(8 - i));
    end
  endtask

  task automatic end_frame();
`ifdef SIPO_DESER_PARITY_EN
    sin    = (^last_seq) ^ par_flip;
    sin_en = 1'b1;
    tick();
    sin_en = 1'b0;
    sin    = 1'b0;
    check("par_err", perr_m, par_flip);
`endif
    check("valid_after_frame", valid_m, 1'b1);
  endtask

  initial begin
    clr_n = 1'b0; start = 1'b0; sin = 1'b0; sin_en = 1'b0;
    dout_ready = 1'b0; ovr_clr = 1'b0;
    tick();
    tick();
    check("rst_dout", dout_m, 8'h00);
    check("rst_valid", valid_m, 1'b0);
    check("rst_busy", busy_m, 1'b0);
    check("rst_overrun", ovr_m, 1'b0);
    clr_n = 1'b1;
    tick();

    // Scenario 1: MSB-first A5, continuous strobe
    begin_frame();
    check("s1_busy", busy_m, 1'b1);
    send_seq(8'b1010_0101, 0, 1'b0);
    end_frame();
    check("s1_dout_msb", dout_m, 8'hA5);
    check("s1_busy_in_hold", busy_m, 1'b0);
    check("s2_dout_lsb_a5", dout_l, 8'hA5);
    handshake();
    check("s1_valid_after_hs", valid_m, 1'b0);

    // Scenario 2: 0x01 sent LSB-first
    begin_frame();
    send_seq(8'b1000_0000, 0, 1'b0);
    end_frame();
    check("s2_dout_lsb_01", dout_l, 8'h01);
    check("s2_dout_msb_80", dout_m, 8'h80);
    handshake();

    // Scenario 3: 3-cycle gaps between bits
    begin_frame();
    send_seq(8'b1010_0101, 3, 1'b1);
    end_frame();
    check("s3_dout", dout_m, 8'hA5);

    // Scenario 4: dropped start in HOLD, clear priority
    start = 1'b1;
    tick();
    start = 1'b0;
    check("s4_overrun_set", ovr_m, 1'b1);
    check("s4_dout_frozen", dout_m, 8'hA5);
    check("s4_valid_kept", valid_m, 1'b1);
    ovr_clr = 1'b1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    check("s4_set_beats_clr", ovr_m, 1'b1);
    tick();
    ovr_clr = 1'b0;
    check("s4_overrun_clr", ovr_m, 1'b0);

    // Scenario 5: handshake + start together, then 3C
    dout_ready = 1'b1;
    start      = 1'b1;
    tick();
    dout_ready = 1'b0;
    start      = 1'b0;
    check("s5_busy_b2b", busy_m, 1'b1);
    check("s5_valid_b2b", valid_m, 1'b0);
    check("s5_dout_cleared", dout_m, 8'h00);
    begin_frame();
    check("s5_start_in_shift_no_ovr", ovr_m, 1'b0);
    send_seq(8'b0011_1100, 0, 1'b0);
    end_frame();
    check("s5_dout_msb", dout_m, 8'h3C);
    check("s5_dout_lsb", dout_l, 8'h3C);
    handshake();

    // Scenario 6: reset mid-frame, then FF
    begin_frame();
    for (int i = 0; i < 4; i++) begin
      sin = 1'b1; sin_en = 1'b1;
      tick();
    end
    sin = 1'b0; sin_en = 1'b0;
    check("s6_partial_dout", dout_m, 8'h0F);
    clr_n = 1'b0;
    #1;
    check("s6_rst_dout", dout_m, 8'h00);
    check("s6_rst_valid", valid_m, 1'b0);
    check("s6_rst_busy", busy_m, 1'b0);
    tick();
    clr_n = 1'b1;
    tick();
    check("s6_no_valid_after_rst", valid_m, 1'b0);
    begin_frame();
    send_seq(8'hFF, 0, 1'b0);
    end_frame();
    check("s6_dout_ff", dout_m, 8'hFF);
    handshake();

`ifdef SIPO_DESER_PARITY_EN
    begin_frame();
    send_seq(8'hA5, 0, 1'b0);
    par_flip = 1'b1;
    end_frame();
    handshake();
    check("par_err_cleared", perr_m, 1'b0);
    par_flip = 1'b0;
    begin_frame();
    send_seq(8'hA5, 0, 1'b0);
    end_frame();
    handshake();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
